keypad_scan: RTL and testbench

Matrix keypad front end for the vending trade controller. It drives a 4-row × 5-column active-low key matrix and synchronises and debounces the column returns. Each clean new press becomes a single-cycle `area_flag` key code. It also maintains the registered `goods_index` selection that the trade controller consumes.

---
 rtl/keypad_scan.sv | 141 ++++++++++++++
 tb/tb_keypad_scan.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// Keypad front end: drives a 4x5 active-low matrix one row at a time,
// synchronises and debounces the column returns, and turns each clean new
// press into a one-cycle key code plus a registered goods selection.
//
// state | meaning
// IDLE  | no debounced key down, next accepted press may pulse
// HELD  | some debounced key down (or multi-key / unused), wait for full release
module keypad_scan #(
  parameter int SCAN_DIV  = 4,
  parameter int DEB_SCANS = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] col_n,
  output logic [3:0] row_n,
  output logic [4:0] area_flag,
  output logic [3:0] goods_index
);

  localparam int              DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_TC   = 4'(DEB_SCANS);

  typedef enum logic {IDLE, HELD} state_t;

  logic [4:0]    col_s1, col_s2;
  logic [4:0]    key;
  logic [DW-1:0] div_cnt;
  logic [1:0]    row_idx;
  logic [19:0]   raw, last_raw, deb_vec;
  logic          scan_done;
  logic [3:0]    stab_cnt;
  state_t        state, state_nxt;
  logic [4:0]    flag_nxt;
  logic [3:0]    goods_nxt;
  logic [4:0]    hot_code;
  logic          one_hot;

  assign key = ~col_s2;

  // two-flop synchroniser for the asynchronous column returns
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_s1 <= 5'h1f;
      col_s2 <= 5'h1f;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  // row scan: hold each row SCAN_DIV cycles, snapshot its columns on the wrap edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt   <= '0;
      row_idx   <= 2'd0;
      row_n     <= 4'b1110;
      raw       <= '0;
      scan_done <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      row_idx   <= row_idx + 2'd1;
      row_n     <= {row_n[2:0], row_n[3]};
      scan_done <= (row_idx == 2'd3);
      case (row_idx)
        2'd0:    raw[4:0]   <= key;
        2'd1:    raw[9:5]   <= key;
        2'd2:    raw[14:10] <= key;
        default: raw[19:15] <= key;
      endcase
    end else begin
      div_cnt   <= div_cnt + 1'b1;
      scan_done <= 1'b0;
    end
  end

  // debounce: a full-matrix vector must repeat DEB_SCANS scans before it is accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_raw <= '0;
      deb_vec  <= '0;
      stab_cnt <= '0;
    end else if (scan_done) begin
      if (raw == last_raw) begin
        if (stab_cnt != DEB_TC) begin
          stab_cnt <= stab_cnt + 4'd1;
          if (stab_cnt == DEB_TC - 4'd1) deb_vec <= raw;
        end
      end else begin
        stab_cnt <= '0;
        last_raw <= raw;
      end
    end
  end

  // key code of the highest set bit; only meaningful when exactly one bit is set
  always_comb begin
    hot_code = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (deb_vec[i]) hot_code = 5'(i + 1);
    end
    one_hot = (deb_vec != 20'd0) && ((deb_vec & (deb_vec - 20'd1)) == 20'd0);
  end

  // press FSM next state, pulse and selection update
  always_comb begin
    state_nxt = state;
    flag_nxt  = 5'd0;
    goods_nxt = goods_index;
    unique case (state)
      IDLE: begin
        if (deb_vec != 20'd0) begin
          state_nxt = HELD;
          if (one_hot && hot_code <= 5'd18) begin
            flag_nxt = hot_code;
            if (hot_code <= 5'd12)       goods_nxt = hot_code[3:0];
            else if (hot_code == 5'd16)  goods_nxt = 4'd0;
          end
        end
      end
      HELD: begin
        if (deb_vec == 20'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // press FSM registers; pulse and selection move on the same edge as the state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      area_flag   <= 5'd0;
      goods_index <= 4'd0;
    end else begin
      state       <= state_nxt;
      area_flag   <= flag_nxt;
      goods_index <= goods_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: matrix model drives col_n from row_n, a snapshot-level
// reference model predicts row_n/area_flag/goods_index every cycle, and
// directed scenarios pin pulse counts, codes and latency with literals.
module tb_keypad_scan;
  localparam int SD  = 4;
  localparam int DEB = 2;
  localparam int P   = 4 * SD;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [4:0] col_n;
  logic [3:0] row_n;
  logic [4:0] area_flag;
  logic [3:0] goods_index;
  logic [19:0] key_vec = '0;

  int checks = 0;
  int failures = 0;
  int k;
  int cyc = 0;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(SD), .DEB_SCANS(DEB)) dut (
    .clk(clk), .rstn(rstn), .col_n(col_n),
    .row_n(row_n), .area_flag(area_flag), .goods_index(goods_index)
  );

  // matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_n = 5'h1f;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (key_vec[5*r+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) k <= 0;
    else       k <= k + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=[%0d..%0d] cyc=%0d", name, act, lo, hi, cyc);
    end
  endtask

  // observed pulses
  int p_code[$];
  int p_time[$];
  int p_goods[$];

  // reference model state
  logic [19:0] hist [4];
  logic [19:0] m_raw, m_last, m_deb;
  int          m_stab;
  bit          m_held;
  int          pend_k = -1;
  int          pend_code;
  logic [3:0]  m_goods;
  logic [4:0]  prev_flag;

  always @(negedge clk) begin
    logic [4:0] exp_flag;
    logic [3:0] exp_row;
    logic [3:0] one;
    int r, code;
    one = 4'b0001;
    if (!rstn) begin
      for (int i = 0; i < 4; i++) hist[i] = '0;
      m_raw = '0; m_last = '0; m_deb = '0; m_stab = 0; m_held = 0;
      pend_k = -1; m_goods = 4'd0; prev_flag = 5'd0;
      chk("rst_row_n", int'(row_n), 14);
      chk("rst_area_flag", int'(area_flag), 0);
      chk("rst_goods", int'(goods_index), 0);
    end else begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = key_vec;
      exp_flag = 5'd0;
      if (pend_k == k) begin
        exp_flag = 5'(pend_code);
        if (pend_code >= 1 && pend_code <= 12) m_goods = 4'(pend_code);
        else if (pend_code == 16)               m_goods = 4'd0;
        pend_k = -1;
      end
      exp_row = ~(one << ((k / SD) % 4));
      chk("row_n", int'(row_n), int'(exp_row));
      chk("area_flag", int'(area_flag), int'(exp_flag));
      chk("goods_index", int'(goods_index), int'(m_goods));
      if (area_flag != 5'd0) begin
        chk("no_back_to_back", int'(prev_flag), 0);
        p_code.push_back(int'(area_flag));
        p_time.push_back(cyc);
        p_goods.push_back(int'(goods_index));
      end
      prev_flag = area_flag;
      // row snapshot: value seen by the synchroniser three cycles earlier
      if (k > 0 && (k % SD) == 0) begin
        r = ((k / SD) - 1) % 4;
        m_raw[5*r +: 5] = hist[3][5*r +: 5];
        if (r == 3) begin
          if (m_raw == m_last) begin
            if (m_stab < DEB) begin
              m_stab++;
              if (m_stab == DEB) m_deb = m_raw;
            end
          end else begin
            m_stab = 0;
            m_last = m_raw;
          end
          if (!m_held) begin
            if (m_deb != 0) begin
              m_held = 1;
              if ($countones(m_deb) == 1) begin
                code = 0;
                for (int i = 0; i < 20; i++) if (m_deb[i]) code = i + 1;
                if (code <= 18) begin
                  pend_k = k + 2;
                  pend_code = code;
                end
              end
            end
          end else if (m_deb == 0) begin
            m_held = 0;
          end
        end
      end
    end
  end

  function automatic logic [19:0] bitv(input int i);
    logic [19:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic p_clear();
    p_code.delete();
    p_time.delete();
    p_goods.delete();
  endtask

  int t0, hs, sel, hold;

  initial begin
    key_vec = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    tick(40);

    // single press and release of code 14
    p_clear();
    t0 = cyc;
    key_vec = bitv(13);
    tick(200);
    key_vec = '0;
    tick(100);
    chk("s1_pulse_count", p_code.size(), 1);
    if (p_code.size() >= 1) begin
      chk("s1_code", p_code[0], 14);
      chk_range("s1_latency", p_time[0] - t0, 1, (DEB + 2) * P + 4);
    end
    chk("s1_goods", int'(goods_index), 0);

    // goods select then clear
    p_clear();
    key_vec = bitv(6);  tick(120);
    key_vec = '0;       tick(100);
    key_vec = bitv(15); tick(120);
    key_vec = '0;       tick(100);
    chk("s2_pulse_count", p_code.size(), 2);
    if (p_code.size() == 2) begin
      chk("s2_code_a", p_code[0], 7);
      chk("s2_goods_a", p_goods[0], 7);
      chk("s2_code_b", p_code[1], 16);
      chk("s2_goods_b", p_goods[1], 0);
    end

    // bounce on code 17, then stable hold
    p_clear();
    for (int i = 0; i < 14; i++) begin
      key_vec = key_vec ^ bitv(16);
      tick(3);
    end
    chk("s3_bounce_pulses", p_code.size(), 0);
    key_vec = bitv(16);
    hs = cyc;
    tick(150);
    key_vec = '0;
    tick(100);
    chk("s3_pulse_count", p_code.size(), 1);
    if (p_code.size() >= 1) begin
      chk("s3_code", p_code[0], 17);
      chk_range("s3_latency", p_time[0] - hs, 1, (DEB + 2) * P + 4);
    end

    // multi-key lockout
    p_clear();
    key_vec = bitv(0) | bitv(4); tick(150);
    key_vec = '0;                tick(100);
    chk("s4_multi_pulses", p_code.size(), 0);
    key_vec = bitv(4);           tick(150);
    key_vec = bitv(4) | bitv(0); tick(100);
    key_vec = '0;                tick(100);
    chk("s4_pulse_count", p_code.size(), 1);
    if (p_code.size() >= 1) chk("s4_code", p_code[0], 5);
    chk("s4_goods", int'(goods_index), 5);

    // unused key locks out a later press
    p_clear();
    key_vec = bitv(19);            tick(100);
    key_vec = bitv(19) | bitv(12); tick(100);
    key_vec = '0;                  tick(100);
    chk("s5_unused_pulses", p_code.size(), 0);

    // reset while code 18 is held
    key_vec = bitv(17);
    tick(120);
    rstn = 1'b0;
    #1;
    chk("s5_async_row_n", int'(row_n), 14);
    chk("s5_async_flag", int'(area_flag), 0);
    chk("s5_async_goods", int'(goods_index), 0);
    tick(3);
    p_clear();
    rstn = 1'b1;
    tick(120);
    chk("s5_post_reset_count", p_code.size(), 1);
    if (p_code.size() >= 1) chk("s5_post_reset_code", p_code[0], 18);
    key_vec = '0;
    tick(100);

    // randomized presses, checked cycle by cycle against the model
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 2)      key_vec = '0;
      else if (sel <= 8) key_vec = bitv($urandom_range(0, 19));
      else               key_vec = bitv($urandom_range(0, 19)) | bitv($urandom_range(0, 19));
      hold = $urandom_range(10, 150);
      tick(hold);
    end
    key_vec = '0;
    tick(120);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
